// File: rtl/binary_to_gray_counter.sv
// Up/down binary counter with a registered Gray-code mirror and a one-cycle wrap pulse.
// Load has priority over count enable; both binary and Gray outputs come straight from flops.
module binary_to_gray_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] gray_out,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  logic [WIDTH-1:0] bin_next;
  logic [WIDTH-1:0] gray_next;
  logic             wrap_next;

  // Next count: load > step > hold; wrap flags only a step across the 0 / all-ones seam
  always_comb begin
    bin_next  = bin_out;
    wrap_next = 1'b0;
    if (load) begin
      bin_next = load_val;
    end else if (en) begin
      if (up_dn) begin
        bin_next  = bin_out + ONE;
        wrap_next = (bin_out == ALL_ONES);
      end else begin
        bin_next  = bin_out - ONE;
        wrap_next = (bin_out == '0);
      end
    end
    gray_next = bin_next ^ (bin_next >> 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_out  <= '0;
      gray_out <= '0;
      wrap     <= 1'b0;
    end else begin
      bin_out  <= bin_next;
      gray_out <= gray_next;
      wrap     <= wrap_next;
    end
  end

endmodule
